// File: rtl/barrel_pkg.sv
// Shared constants and helpers for the transmit-side barrel shifter and the
// receive-side barrel unshifter.
package barrel_pkg;

    localparam int DEF_N     = 16;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_K     = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Bit offset of the least significant bit of element j.
    function automatic int elem_lo(input int j, input int width = DEF_WIDTH);
        return j * width;
    endfunction

endpackage

// File: rtl/barrel_unshifter_stage.sv
// One pipeline stage of the inverse barrel rotator: right-rotates by
// 2^STAGE_NUM elements when sel bit STAGE_NUM is set, and holds when adv=0.
module barrel_unshifter_stage
    import barrel_pkg::*;
#(
    parameter int STAGE_NUM = 0,
    parameter int N         = DEF_N,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int K         = DEF_K,
    parameter bit STORE_SEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv_i,
    input  logic                 valid_i,
    input  logic [N*WIDTH-1:0]   data_i,
    input  logic [K-1:0]         sel_i,
    output logic                 valid_o,
    output logic [N*WIDTH-1:0]   data_o,
    output logic [K-1:0]         sel_o
);

    localparam int SHIFT = 1 << STAGE_NUM;

    logic                 valid_q;
    logic [N*WIDTH-1:0]   data_q;
    logic [N*WIDTH-1:0]   rot;
    logic [N*WIDTH-1:0]   data_d;

    // Result element i takes upstream element (i + 2^STAGE_NUM) mod N.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[elem_lo(i, WIDTH) +: WIDTH] = data_i[elem_lo((i + SHIFT) % N, WIDTH) +: WIDTH];
        end
        data_d = sel_i[STAGE_NUM] ? rot : data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
        end
    end

    if (STORE_SEL) begin : g_sel
        logic [K-1:0] sel_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sel_q <= '0;
            end else if (adv_i) begin
                sel_q <= sel_i;
            end
        end

        assign sel_o = sel_q;
    end else begin : g_no_sel
        logic sel_unused;
        assign sel_unused = ^sel_i;
        assign sel_o      = '0;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/barrel_unshifter.sv
// K-stage pipelined inverse barrel rotator with valid/ready flow control.
// Define BARREL_UNSHIFTER_SEL_ECHO_EN to add out_sel (sel that travelled with out_data).
module barrel_unshifter
    import barrel_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int K     = DEF_K
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [K-1:0]         sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_data
`ifdef BARREL_UNSHIFTER_SEL_ECHO_EN
    ,
    output logic [K-1:0]         out_sel
`endif
);

`ifdef BARREL_UNSHIFTER_SEL_ECHO_EN
    localparam bit LAST_STORES_SEL = 1'b1;
`else
    localparam bit LAST_STORES_SEL = 1'b0;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; a stage advances when it is empty or everything below it advances.
    logic [K-1:0]         adv;
    logic [K:0]           chain_valid;
    logic [N*WIDTH-1:0]   chain_data [K+1];
    logic [K-1:0]         chain_sel  [K+1];
    logic                 all_full;

    // adv[s] = out_ready | !(valid[s] & ... & valid[K-1]), unrolled without self-reference.
    always_comb begin
        adv      = '0;
        all_full = 1'b1;
        for (int s = K - 1; s >= 0; s--) begin
            all_full = all_full & chain_valid[s+1];
            adv[s]   = out_ready | ~all_full;
        end
    end

    assign chain_valid[0] = in_valid;
    assign chain_data[0]  = in_data;
    assign chain_sel[0]   = sel;

    for (genvar s = 0; s < K; s++) begin : g_stage
        barrel_unshifter_stage #(
            .STAGE_NUM (s),
            .N         (N),
            .WIDTH     (WIDTH),
            .K         (K),
            .STORE_SEL ((s < K - 1) ? 1'b1 : LAST_STORES_SEL)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (adv[s]),
            .valid_i (chain_valid[s]),
            .data_i  (chain_data[s]),
            .sel_i   (chain_sel[s]),
            .valid_o (chain_valid[s+1]),
            .data_o  (chain_data[s+1]),
            .sel_o   (chain_sel[s+1])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = chain_valid[K];
    assign out_data  = chain_data[K];

`ifdef BARREL_UNSHIFTER_SEL_ECHO_EN
    assign out_sel = chain_sel[K];
`else
    logic last_sel_unused;
    assign last_sel_unused = ^chain_sel[K];
`endif

endmodule
